// File: rtl/acc_store_ctrl.sv
// acc_store_ctrl: writes a snapshot of the accumulator to data memory over a
// request/acknowledge bus. It keeps one command in flight and one pending, and
// aborts a write that is never acknowledged.
//
// All registers update on the falling edge of clock. reset is asynchronous and
// active-low.
//
// Ports:
//   clock, reset          falling-edge clock, async active-low reset
//   StoreReq              one-cycle store command strobe
//   StoreAddr             target address, valid with StoreReq
//   ACCDataIn             accumulator data to store
//   ACCNegIn, ACCZeroIn   accumulator flags, captured with the command
//   MemAck                memory write acknowledge, only honoured in REQ
//   MemReq, MemWr         memory write request (MemWr mirrors MemReq)
//   MemAddr, MemDataOut   write address and data (data is 0 when MemReq is low)
//   StoreBusy             a transaction is in flight or pending
//   StoreFull             pending slot occupied
//   StoreDone             one-cycle pulse, write acknowledged
//   StoreErr              one-cycle pulse, write aborted on timeout
//   StoreRej              one-cycle pulse, command dropped because slot full
//   FlagNeg, FlagZero     flags captured with the last issued store
module acc_store_ctrl #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned TimeoutCycles = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 StoreReq,
  input  logic [AddrWidth-1:0] StoreAddr,
  input  logic [DataWidth-1:0] ACCDataIn,
  input  logic                 ACCNegIn,
  input  logic                 ACCZeroIn,
  input  logic                 MemAck,
  output logic                 MemReq,
  output logic                 MemWr,
  output logic [AddrWidth-1:0] MemAddr,
  output logic [DataWidth-1:0] MemDataOut,
  output logic                 StoreBusy,
  output logic                 StoreFull,
  output logic                 StoreDone,
  output logic                 StoreErr,
  output logic                 StoreRej,
  output logic                 FlagNeg,
  output logic                 FlagZero
);

  localparam int unsigned CntWidth = 8;
  // Last counter value before the abort edge: the edge that would move the
  // counter to TimeoutCycles is the one that aborts.
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // FSM decisions shared with the datapath
  logic issue_new_c;   // IDLE with empty slot: command goes straight to the bus
  logic issue_pend_c;  // pending slot moves to the bus this edge
  logic ack_hit_c;
  logic timeout_hit_c;

  // Pending slot
  logic                 pend_valid_q, pend_valid_d;
  logic [AddrWidth-1:0] pend_addr_q,  pend_addr_d;
  logic [DataWidth-1:0] pend_data_q,  pend_data_d;
  logic                 pend_neg_q,   pend_neg_d;
  logic                 pend_zero_q,  pend_zero_d;

  // Timeout counter
  logic [CntWidth-1:0]  cnt_q, cnt_d;

  // Output registers
  logic                 mem_req_q,  mem_req_d;
  logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0] mem_data_q, mem_data_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;
  logic                 err_q,      err_d;
  logic                 rej_q,      rej_d;
  logic                 flag_neg_q, flag_neg_d;
  logic                 flag_zero_q, flag_zero_d;

  logic slot_capture_c;
  logic reject_c;

  // State and datapath registers
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      pend_neg_q   <= 1'b0;
      pend_zero_q  <= 1'b0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rej_q        <= 1'b0;
      flag_neg_q   <= 1'b0;
      flag_zero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      pend_neg_q   <= pend_neg_d;
      pend_zero_q  <= pend_zero_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rej_q        <= rej_d;
      flag_neg_q   <= flag_neg_d;
      flag_zero_q  <= flag_zero_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    issue_new_c   = 1'b0;
    issue_pend_c  = 1'b0;
    ack_hit_c     = 1'b0;
    timeout_hit_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A slot filled during the DONE turnaround is drained from IDLE.
        if (pend_valid_q) begin
          state_d      = REQ;
          issue_pend_c = 1'b1;
        end else if (StoreReq) begin
          state_d     = REQ;
          issue_new_c = 1'b1;
        end
      end
      REQ: begin
        if (MemAck) begin
          state_d   = DONE;
          ack_hit_c = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d       = DONE;
          timeout_hit_c = 1'b1;
        end
      end
      DONE: begin
        if (pend_valid_q) begin
          state_d      = REQ;
          issue_pend_c = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    pend_neg_d  = pend_neg_q;
    pend_zero_d = pend_zero_q;
    mem_addr_d  = mem_addr_q;
    flag_neg_d  = flag_neg_q;
    flag_zero_d = flag_zero_q;
    cnt_d       = cnt_q;

    // The slot accepts a command when empty, or when it is being drained now.
    slot_capture_c = StoreReq && !issue_new_c && (!pend_valid_q || issue_pend_c);
    reject_c       = StoreReq && pend_valid_q && !issue_pend_c;

    pend_valid_d = (pend_valid_q && !issue_pend_c) || slot_capture_c;
    if (slot_capture_c) begin
      pend_addr_d = StoreAddr;
      pend_data_d = ACCDataIn;
      pend_neg_d  = ACCNegIn;
      pend_zero_d = ACCZeroIn;
    end

    // Bus data is driven only while requesting; otherwise forced to zero.
    mem_data_d = (state_d == REQ) ? mem_data_q : '0;
    if (issue_new_c) begin
      mem_addr_d  = StoreAddr;
      mem_data_d  = ACCDataIn;
      flag_neg_d  = ACCNegIn;
      flag_zero_d = ACCZeroIn;
    end else if (issue_pend_c) begin
      mem_addr_d  = pend_addr_q;
      mem_data_d  = pend_data_q;
      flag_neg_d  = pend_neg_q;
      flag_zero_d = pend_zero_q;
    end

    // Counter clears on every entry to REQ and counts unacknowledged edges.
    if (state_d == REQ && state_q != REQ) begin
      cnt_d = '0;
    end else if (state_d == REQ && state_q == REQ) begin
      cnt_d = cnt_q + CntWidth'(1);
    end

    mem_req_d = (state_d == REQ);
    busy_d    = (state_d != IDLE) || pend_valid_d;
    done_d    = ack_hit_c;
    err_d     = timeout_hit_c;
    rej_d     = reject_c;
  end

  assign MemReq     = mem_req_q;
  assign MemWr      = mem_req_q;
  assign MemAddr    = mem_addr_q;
  assign MemDataOut = mem_data_q;
  assign StoreBusy  = busy_q;
  assign StoreFull  = pend_valid_q;
  assign StoreDone  = done_q;
  assign StoreErr   = err_q;
  assign StoreRej   = rej_q;
  assign FlagNeg    = flag_neg_q;
  assign FlagZero   = flag_zero_q;

endmodule

// File: tb/tb_acc_store_ctrl.sv
// Directed bench for acc_store_ctrl. DUT registers move on the falling edge;
// the bench drives and samples on the rising edge.
module tb_acc_store_ctrl;

  logic        clock;
  logic        reset;
  logic        StoreReq;
  logic [31:0] StoreAddr;
  logic [31:0] ACCDataIn;
  logic        ACCNegIn;
  logic        ACCZeroIn;
  logic        MemAck;
  logic        MemReq;
  logic        MemWr;
  logic [31:0] MemAddr;
  logic [31:0] MemDataOut;
  logic        StoreBusy;
  logic        StoreFull;
  logic        StoreDone;
  logic        StoreErr;
  logic        StoreRej;
  logic        FlagNeg;
  logic        FlagZero;

  int total = 0;
  int bad   = 0;

  acc_store_ctrl #(
    .DataWidth(32),
    .AddrWidth(32),
    .TimeoutCycles(15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .StoreReq(StoreReq),
    .StoreAddr(StoreAddr),
    .ACCDataIn(ACCDataIn),
    .ACCNegIn(ACCNegIn),
    .ACCZeroIn(ACCZeroIn),
    .MemAck(MemAck),
    .MemReq(MemReq),
    .MemWr(MemWr),
    .MemAddr(MemAddr),
    .MemDataOut(MemDataOut),
    .StoreBusy(StoreBusy),
    .StoreFull(StoreFull),
    .StoreDone(StoreDone),
    .StoreErr(StoreErr),
    .StoreRej(StoreRej),
    .FlagNeg(FlagNeg),
    .FlagZero(FlagZero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},  32'(MemReq), 32'd0);
    chk({tag, "_wr"},   32'(MemWr), 32'd0);
    chk({tag, "_addr"}, MemAddr, 32'd0);
    chk({tag, "_data"}, MemDataOut, 32'd0);
    chk({tag, "_busy"}, 32'(StoreBusy), 32'd0);
    chk({tag, "_full"}, 32'(StoreFull), 32'd0);
    chk({tag, "_done"}, 32'(StoreDone), 32'd0);
    chk({tag, "_err"},  32'(StoreErr), 32'd0);
    chk({tag, "_rej"},  32'(StoreRej), 32'd0);
    chk({tag, "_neg"},  32'(FlagNeg), 32'd0);
    chk({tag, "_zero"}, 32'(FlagZero), 32'd0);
  endtask

  task automatic cmd(input logic [31:0] a, input logic [31:0] d, input logic n, input logic z);
    StoreReq  = 1'b1;
    StoreAddr = a;
    ACCDataIn = d;
    ACCNegIn  = n;
    ACCZeroIn = z;
  endtask

  initial begin
    reset = 1'b0; StoreReq = 1'b0; StoreAddr = '0; ACCDataIn = '0;
    ACCNegIn = 1'b0; ACCZeroIn = 1'b0; MemAck = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();

    // Single store, ack after 3 cycles
    cmd(32'h100, 32'h8000_0001, 1'b1, 1'b0);
    tick(); StoreReq = 1'b0;
    chk("s1_req", 32'(MemReq), 32'd1);
    chk("s1_wr", 32'(MemWr), 32'd1);
    chk("s1_addr", MemAddr, 32'h100);
    chk("s1_data", MemDataOut, 32'h8000_0001);
    chk("s1_neg", 32'(FlagNeg), 32'd1);
    chk("s1_zero", 32'(FlagZero), 32'd0);
    chk("s1_busy", 32'(StoreBusy), 32'd1);
    tick();
    chk("s1_hold_req", 32'(MemReq), 32'd1);
    chk("s1_hold_done", 32'(StoreDone), 32'd0);
    tick();
    chk("s1_hold_addr", MemAddr, 32'h100);
    MemAck = 1'b1;
    tick(); MemAck = 1'b0;
    chk("s1_done", 32'(StoreDone), 32'd1);
    chk("s1_req_drop", 32'(MemReq), 32'd0);
    chk("s1_data_zero", MemDataOut, 32'd0);
    chk("s1_err", 32'(StoreErr), 32'd0);
    tick();
    chk("s1_done_once", 32'(StoreDone), 32'd0);
    chk("s1_idle_busy", 32'(StoreBusy), 32'd0);

    // Zero value with MemAck held high
    cmd(32'h200, 32'h0, 1'b0, 1'b1);
    MemAck = 1'b1;
    tick(); StoreReq = 1'b0;
    chk("s2_req", 32'(MemReq), 32'd1);
    chk("s2_zero", 32'(FlagZero), 32'd1);
    chk("s2_neg", 32'(FlagNeg), 32'd0);
    tick();
    chk("s2_req_1cyc", 32'(MemReq), 32'd0);
    chk("s2_done", 32'(StoreDone), 32'd1);
    tick();
    chk("s2_gap", 32'(MemReq), 32'd0);
    chk("s2_done_once", 32'(StoreDone), 32'd0);
    MemAck = 1'b0;
    tick();

    // Back-to-back with a rejected third command
    cmd(32'h10, 32'hA, 1'b0, 1'b0);
    tick();
    chk("s3_a_addr", MemAddr, 32'h10);
    chk("s3_a_data", MemDataOut, 32'hA);
    cmd(32'h14, 32'hB, 1'b0, 1'b0);
    tick();
    chk("s3_full", 32'(StoreFull), 32'd1);
    chk("s3_a_hold", MemAddr, 32'h10);
    cmd(32'h18, 32'hC, 1'b1, 1'b0);
    tick(); StoreReq = 1'b0;
    chk("s3_rej", 32'(StoreRej), 32'd1);
    chk("s3_full_kept", 32'(StoreFull), 32'd1);
    chk("s3_a_data_hold", MemDataOut, 32'hA);
    tick();
    chk("s3_rej_once", 32'(StoreRej), 32'd0);
    MemAck = 1'b1;
    tick(); MemAck = 1'b0;
    chk("s3_a_done", 32'(StoreDone), 32'd1);
    chk("s3_gap", 32'(MemReq), 32'd0);
    tick();
    chk("s3_b_req", 32'(MemReq), 32'd1);
    chk("s3_b_addr", MemAddr, 32'h14);
    chk("s3_b_data", MemDataOut, 32'hB);
    chk("s3_b_full", 32'(StoreFull), 32'd0);
    chk("s3_b_done_low", 32'(StoreDone), 32'd0);
    MemAck = 1'b1;
    tick(); MemAck = 1'b0;
    chk("s3_b_done", 32'(StoreDone), 32'd1);
    tick();
    chk("s3_idle", 32'(StoreBusy), 32'd0);

    // Timeout with a pending command behind it
    cmd(32'h300, 32'h55, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 1) cmd(32'h304, 32'h66, 1'b1, 1'b0);
      else StoreReq = 1'b0;
      chk("s4_req_high", 32'(MemReq), 32'd1);
      chk("s4_no_err", 32'(StoreErr), 32'd0);
    end
    tick();
    chk("s4_req_drop", 32'(MemReq), 32'd0);
    chk("s4_err", 32'(StoreErr), 32'd1);
    chk("s4_no_done", 32'(StoreDone), 32'd0);
    tick();
    chk("s4_err_once", 32'(StoreErr), 32'd0);
    chk("s4_p_req", 32'(MemReq), 32'd1);
    chk("s4_p_addr", MemAddr, 32'h304);
    chk("s4_p_data", MemDataOut, 32'h66);
    chk("s4_p_neg", 32'(FlagNeg), 32'd1);
    MemAck = 1'b1;
    tick(); MemAck = 1'b0;
    chk("s4_p_done", 32'(StoreDone), 32'd1);
    tick();

    // Ack on the timeout edge wins
    cmd(32'h380, 32'h99, 1'b0, 1'b0);
    for (int i = 1; i <= 14; i++) begin
      tick(); StoreReq = 1'b0;
      chk("s5_req_high", 32'(MemReq), 32'd1);
    end
    tick();
    chk("s5_req_15", 32'(MemReq), 32'd1);
    MemAck = 1'b1;
    tick(); MemAck = 1'b0;
    chk("s5_done", 32'(StoreDone), 32'd1);
    chk("s5_no_err", 32'(StoreErr), 32'd0);
    chk("s5_req_drop", 32'(MemReq), 32'd0);
    tick();
    chk("s5_err_after", 32'(StoreErr), 32'd0);
    tick();

    // Reset mid-operation with the slot full
    cmd(32'h400, 32'h77, 1'b1, 1'b0);
    tick();
    cmd(32'h404, 32'h78, 1'b0, 1'b0);
    tick(); StoreReq = 1'b0;
    chk("s6_full", 32'(StoreFull), 32'd1);
    chk("s6_req", 32'(MemReq), 32'd1);
    #2 reset = 1'b0;
    #1 chk_all_zero("s6_async");
    tick();
    chk_all_zero("s6_held");
    reset = 1'b1;
    tick();
    chk("s6_idle_done", 32'(StoreDone), 32'd0);
    chk("s6_idle_req", 32'(MemReq), 32'd0);
    cmd(32'h500, 32'h1234_5678, 1'b0, 1'b0);
    tick(); StoreReq = 1'b0;
    chk("s6_new_req", 32'(MemReq), 32'd1);
    chk("s6_new_addr", MemAddr, 32'h500);
    chk("s6_new_data", MemDataOut, 32'h1234_5678);
    chk("s6_new_full", 32'(StoreFull), 32'd0);
    MemAck = 1'b1;
    tick(); MemAck = 1'b0;
    chk("s6_new_done", 32'(StoreDone), 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
